// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Round-robin scheduler that multiplexes NUM_REQ byte streams onto a single
// UART transmitter input. A grant is locked for one packet (until req_last or
// BURST_MAX bytes) and GAP_CYCLES idle cycles follow every accepted byte.
// tx_valid/tx_data are a combinational passthrough of the granted requester,
// so tx_ready never feeds tx_valid.

module uart_tx_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            tx_valid,
  output logic [DATA_WIDTH-1:0]           tx_data,
  input  logic                            tx_ready,
  output logic                            grant_active,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(BURST_MAX + 1);
  localparam int GC_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [GID_W-1:0] GID_MAX   = GID_W'(NUM_REQ - 1);
  localparam logic [BC_W-1:0]  BURST_TOP = BC_W'(BURST_MAX);
  localparam logic [GC_W-1:0]  GAP_LOAD  = (GAP_CYCLES > 0) ? GC_W'(GAP_CYCLES - 1) : {GC_W{1'b0}};

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [GID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]       grant_id_q, grant_id_d;
  logic                   grant_active_q, grant_active_d;
  logic [BC_W-1:0]        burst_cnt_q, burst_cnt_d;
  logic [GC_W-1:0]        gap_cnt_q, gap_cnt_d;
  logic                   done_q, done_d;

  logic                   arb_hit_s;
  logic [GID_W-1:0]       arb_id_s;
  logic [GID_W-1:0]       arb_cand_s;
  logic                   xfer_s;
  logic                   done_now_s;
  logic [GID_W-1:0]       rel_ptr_s;
  logic [DATA_WIDTH-1:0]  data_sel_s;

  // Byte of the granted requester and the packet-end / pointer-advance terms.
  assign data_sel_s = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign xfer_s     = (state_q == ST_SEND) && req_valid[grant_id_q] && tx_ready;
  assign done_now_s = req_last[grant_id_q] || ((burst_cnt_q + BC_W'(1)) == BURST_TOP);
  assign rel_ptr_s  = (grant_id_q == GID_MAX) ? {GID_W{1'b0}} : (grant_id_q + GID_W'(1));

  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    arb_hit_s  = 1'b0;
    arb_id_s   = {GID_W{1'b0}};
    arb_cand_s = {GID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_cand_s = GID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!arb_hit_s && req_valid[arb_cand_s]) begin
        arb_hit_s = 1'b1;
        arb_id_s  = arb_cand_s;
      end else begin
        arb_hit_s = arb_hit_s;
      end
    end
  end

  // State register and all scheduler flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_ARB;
      rr_ptr_q       <= {GID_W{1'b0}};
      grant_id_q     <= {GID_W{1'b0}};
      grant_active_q <= 1'b0;
      burst_cnt_q    <= {BC_W{1'b0}};
      gap_cnt_q      <= {GC_W{1'b0}};
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      burst_cnt_q    <= burst_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      done_q         <= done_d;
    end
  end

  // Next-state logic: grant in ARB, count bytes in SEND, pace bytes in GAP.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    burst_cnt_d    = burst_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    done_d         = done_q;
    case (state_q)
      ST_ARB: begin
        if (enable && arb_hit_s) begin
          state_d        = ST_SEND;
          grant_id_d     = arb_id_s;
          grant_active_d = 1'b1;
          burst_cnt_d    = {BC_W{1'b0}};
        end else begin
          grant_active_d = 1'b0;
        end
      end
      ST_SEND: begin
        if (xfer_s) begin
          burst_cnt_d = burst_cnt_q + BC_W'(1);
          done_d      = done_now_s;
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end else if (done_now_s) begin
            state_d        = ST_ARB;
            grant_active_d = 1'b0;
            rr_ptr_d       = rel_ptr_s;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          // Granted requester may stall indefinitely; the grant is held.
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == {GC_W{1'b0}}) begin
          if (done_q) begin
            state_d        = ST_ARB;
            grant_active_d = 1'b0;
            rr_ptr_d       = rel_ptr_s;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GC_W'(1);
        end
      end
      default: begin
        state_d        = ST_ARB;
        grant_active_d = 1'b0;
      end
    endcase
  end

  // Output decode: only SEND exposes the granted requester to the UART.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = {DATA_WIDTH{1'b0}};
    req_ready = {NUM_REQ{1'b0}};
    if (state_q == ST_SEND) begin
      tx_valid = req_valid[grant_id_q];
      tx_data  = data_sel_s;
      for (int k = 0; k < NUM_REQ; k++) begin
        req_ready[k] = tx_ready && (grant_id_q == GID_W'(k));
      end
    end else begin
      tx_valid = 1'b0;
    end
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin scheduler sharing the single UART transmitter byte stream among NUM_REQ requesters (e.g. command echo, status report, debug).
- Locks the grant for a packet (until req_last, or BURST_MAX bytes), then enforces GAP_CYCLES idle cycles after every accepted byte.
- Sits between the requesters and the uart tx byte input, in the same clk domain as the uart core.
- Driven by the synchronised reset.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- DATA_WIDTH, 8, byte width.
- BURST_MAX, 4, max bytes per grant before forced rotation (>=1).
- GAP_CYCLES, 2, idle clk cycles inserted after each accepted byte (0 = none).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits new grants; does not abort a granted packet.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_last  in  NUM_REQ  per-requester final byte of packet; qualified by req_valid.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  byte accepted from requester i this cycle.
- tx_valid  out  1  byte offered to uart tx.
- tx_data  out  DATA_WIDTH  byte to uart tx.
- tx_ready  in  1  uart tx accepts byte (transfer = tx_valid & tx_ready).
- grant_active  out  1  a packet grant is held.
- grant_id  out  clog2(NUM_REQ)  index of granted/last-granted requester.

Behaviour:
- Reset values, async on reset rising:
  - state ARB; rr_ptr 0; grant_id 0; grant_active 0.
  - burst_cnt 0; gap_cnt 0.
  - tx_valid 0; req_ready all 0; tx_data 0.
- States: ARB, SEND, GAP.
- ARB:
  - If enable=1 and any req_valid: grant_id <= first i with req_valid[i], searching from rr_ptr upward with wrap.
  - grant_active <= 1; burst_cnt <= 0; next SEND.
  - Otherwise stay in ARB with grant_active 0.
  - Latency: req_valid sampled in cycle N gives tx_valid=1 in cycle N+1.
- SEND:
  - tx_valid = req_valid[grant_id]; tx_data = req_data[grant_id], combinational passthrough.
  - req_ready[grant_id] = tx_ready; all other req_ready = 0.
  - If the granted requester deasserts valid mid-packet: remain in SEND, grant held, tx_valid 0. No timeout.
  - On transfer:
    - burst_cnt++.
    - done = req_last[grant_id] | (burst_cnt+1 == BURST_MAX).
    - If GAP_CYCLES>0: go to GAP with gap_cnt <= GAP_CYCLES-1.
    - Else if done: go to ARB.
    - Else stay in SEND.
- GAP:
  - tx_valid 0; req_ready 0.
  - gap_cnt decrements each cycle.
  - At gap_cnt==0: go to ARB if done (latched at transfer), else SEND.
- Release on leaving toward ARB:
  - grant_active <= 0.
  - rr_ptr <= grant_id+1, wrapping at NUM_REQ-1 -> 0.
- grant_id holds its value after release (debug visibility).
- Forced rotation: after BURST_MAX bytes, release even without req_last. The same requester may be regranted only if no other requester is valid (round-robin order).
- enable=0: blocks only the ARB decision. A packet in SEND/GAP completes normally.
- Simultaneous requests in ARB: the lowest index at or above rr_ptr wins, with wrap.
- req_valid/req_data of non-granted requesters are ignored. Their req_ready stays 0.
- reset mid-packet: immediate return to reset values. The in-flight byte is dropped unless the transfer completed before reset.
- Counter widths: burst_cnt clog2(BURST_MAX+1); gap_cnt clog2(GAP_CYCLES+1), min 1 bit.
- No combinational path from tx_ready to tx_valid.

Test Plan:
- Single requester: req0 sends 0x41,0x42 (last on 0x42), tx_ready=1, GAP=2.
  - tx_valid high in cycle 1 after req_valid.
  - Bytes emitted 3 cycles apart.
  - Then grant_active=0 and rr_ptr=1.
- Three requesters all valid with 1-byte packets.
  - Emission order 0,1,2,0,1,2.
  - grant_id follows the same order.
  - Each req_ready pulse coincides with tx_ready.
- Burst limit: req1 streams 6 bytes with no last, req2 valid, BURST_MAX=4.
  - 4 bytes from req1, then req2's packet, then req1's remaining 2.
- Backpressure: tx_ready held 0 for 5 cycles in SEND.
  - tx_valid stays 1 with tx_data stable.
  - No req_ready pulse until tx_ready=1.
- enable deasserted mid-packet: the current 3-byte packet completes.
  - No new grant while enable=0.
  - With enable=1, the next requester is granted 1 cycle later.
- Async reset asserted in GAP between clock edges.
  - All outputs go to reset values immediately.
  - After release, arbitration restarts from requester 0.
